mmu_port_arbiter: RTL and testbench
===================================

Name: mmu_port_arbiter

Overview:
- Multi-requester front end for the MMU core; generalises the single-channel request/response FIFO wrapper to NUM_PORTS independent requesters.
- Each port has its own request FIFO and response FIFO. A round-robin arbiter feeds one shared core request interface, and per-port outstanding credits bound the number of in-flight requests.
- Core responses carry a port tag and are routed back to the owning port's response FIFO.
- Sits between user clients and the MMU core (alloc or free path; one instance per path).

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- PORT_W, 2, tag width; must equal clog2(NUM_PORTS), minimum 1.
- REQ_W, 17, request payload width (alloc: 13b id + 4b page count).
- RSP_W, 30, response payload width (13b id + 15b page idx + fail + fail-reason bit).
- FIFO_PTR, 3, per-port FIFO pointer width; depth = 2**FIFO_PTR.
- MAX_OUT, 4, maximum outstanding (granted, unanswered) requests per port (1..15).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_submit  in  NUM_PORTS  per-port request write strobe.
- req_data  in  NUM_PORTS*REQ_W  flattened payloads; port p occupies bits [p*REQ_W +: REQ_W].
- req_fifo_full  out  NUM_PORTS  per-port request FIFO full.
- rsp_pop  in  NUM_PORTS  per-port response pop.
- rsp_data  out  NUM_PORTS*RSP_W  flattened response FIFO heads; valid the cycle after a pop.
- rsp_fifo_not_empty  out  NUM_PORTS  per-port response available.
- core_req_valid  out  1  request presented to core.
- core_req_ready  in  1  core accepts; a transfer occurs when valid&&ready.
- core_req_data  out  REQ_W  granted payload.
- core_req_port  out  PORT_W  granted port tag.
- core_rsp_valid  in  1  core response strobe.
- core_rsp_port  in  PORT_W  response tag.
- core_rsp_data  in  RSP_W  response payload.
- core_rsp_ready  out  1  high when the tagged port's response FIFO is not full.
- out_cnt  out  NUM_PORTS*4  per-port outstanding count (debug).

Behaviour:
- Reset values: core_req_valid=0, core_req_data=0, core_req_port=0, all FIFOs empty (req_fifo_full=0, rsp_fifo_not_empty=0, rsp_data=0), out_cnt=0, round-robin pointer=0.
- Eligibility: port p is eligible when its request FIFO is non-empty and out_cnt[p] < MAX_OUT.
- FSM states:
  - IDLE: if any port is eligible, grant the first eligible port at or after rr_ptr (wrap-around), issue the FIFO pop, go to LOAD.
  - LOAD: capture the FIFO read data into the core_req_data register, drive core_req_port, assert core_req_valid, go to ISSUE.
  - ISSUE: hold core_req_valid/data/port stable until core_req_ready. On the handshake: out_cnt[grant]+1, rr_ptr = grant+1 mod NUM_PORTS, return to IDLE.
- Latency: minimum 2 cycles from a non-empty, eligible FIFO to core_req_valid. Peak throughput is 1 request per 3 cycles.
- Response path:
  - On core_rsp_valid && core_rsp_ready: write core_rsp_data to rsp FIFO[core_rsp_port] and decrement out_cnt[core_rsp_port].
  - core_rsp_ready = ~rsp_fifo_full[core_rsp_port]; evaluated combinationally on the tag.
- Simultaneous grant and response on the same port in one cycle: net out_cnt change is 0.
- Response with out_cnt[p]==0: write the data anyway, leave out_cnt at 0 (no underflow), pulse the internal error flag.
- core_rsp_port >= NUM_PORTS: the response is dropped, core_rsp_ready=1, error flag pulses.
- req_submit while full: ignored; FIFO contents unchanged.
- rsp_pop while empty: ignored; rsp_data holds its previous value.
- Simultaneous write and read on a per-port FIFO: both occur; the count is unchanged.
- rst asserted mid-ISSUE: core_req_valid drops in the next cycle and the in-flight request is discarded. The core must be reset together with this block.

Optional Feature:
- Macro: MMU_ARB_STATS_EN.
- Defined: adds output grant_cnt (NUM_PORTS*16), per-port saturating counters of completed core request handshakes. Counters reset to 0, saturate at 16'hFFFF, and increment the cycle after the handshake.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (mmu_param.vh): PORT_W derivation macro, FSM state encodings (ARB_IDLE=2'd0, ARB_LOAD=2'd1, ARB_ISSUE=2'd2), default widths (REQ_ID_WIDTH, ALL_PAGE_IDX_WIDTH, FAIL_REASON_WIDTH).
- Sub-module: mmu_port_fifo (synchronous FIFO with active-high sync reset, full/empty), instantiated 2*NUM_PORTS times via generate.
- Round-robin select: a function inside the top.

Test Plan:
- Single port: submit port 1 payload 17'h1_0005, ready=1 -> core_req_valid after 2 cycles with data 17'h1_0005, port=1; out_cnt[1]=1.
- All 4 ports submit in the same cycle, ready=1 -> grant order 0,1,2,3; then a repeat submit on port 0 is granted after 3.
- Credit limit: port 2 submits 6 requests, no responses, MAX_OUT=4 -> exactly 4 issued, 2 remain queued. One response tagged 2 -> a 5th request issues.
- Backpressure: core_req_ready=0 for 10 cycles in ISSUE -> valid, data and port stable throughout; the handshake on the 11th cycle increments out_cnt.
- Response routing: core_rsp_port=3 with rsp FIFO 3 full -> core_rsp_ready=0 and no write. After rsp_pop[3], the response is written, rsp_fifo_not_empty[3]=1 and data matches.
- Reset mid-operation: rst=1 during ISSUE -> next cycle core_req_valid=0, out_cnt all 0, every rsp_fifo_not_empty=0.

Source files
------------

// File: rtl/mmu_port_arbiter_pkg.sv
// mmu_port_arbiter_pkg: shared FSM encodings, default payload widths and the
// port-tag width derivation used by mmu_port_arbiter and its FIFOs.
package mmu_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_ISSUE = 2'd2
    } arb_state_t;

    localparam int REQ_ID_WIDTH       = 13;
    localparam int ALL_PAGE_IDX_WIDTH = 15;
    localparam int FAIL_REASON_WIDTH  = 1;

    // Tag width for n ports; a single port still needs a 1-bit tag.
    function automatic int port_w_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmu_port_fifo.sv
// mmu_port_fifo: synchronous FIFO, depth 2**PTR, registered read data.
//   clk, rst         : clock, synchronous active-high reset
//   wr, wdata, full  : write side; writes while full are dropped
//   rd, rdata, empty : read side; rdata updates the cycle after an accepted
//                      read and holds otherwise (reads while empty ignored)
module mmu_port_fifo #(
    parameter int W   = 8,
    parameter int PTR = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty
);

    logic [W-1:0] mem [2**PTR];
    logic [PTR:0] wp, rp;
    logic do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = wp == rp;
    assign full  = (wp[PTR] != rp[PTR]) && (wp[PTR-1:0] == rp[PTR-1:0]);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk)
        if (do_wr) mem[wp[PTR-1:0]] <= wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            rdata <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) begin
                rdata <= mem[rp[PTR-1:0]];
                rp    <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter: NUM_PORTS-requester front end for the MMU core.
//   Per port: request FIFO (req_submit/req_data/req_fifo_full), response FIFO
//   (rsp_pop/rsp_data/rsp_fifo_not_empty) and an outstanding credit (out_cnt).
//   Core side: round-robin granted request (core_req_*) and tagged responses
//   (core_rsp_*), core_rsp_ready reflecting the tagged port's response FIFO.
//   Optional: MMU_ARB_STATS_EN adds grant_cnt, per-port saturating counts of
//   completed core request handshakes.
module mmu_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = mmu_port_arbiter_pkg::port_w_of(NUM_PORTS),
    parameter int REQ_W     = 17,
    parameter int RSP_W     = 30,
    parameter int FIFO_PTR  = 3,
    parameter int MAX_OUT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req_submit,
    input  logic [NUM_PORTS*REQ_W-1:0] req_data,
    output logic [NUM_PORTS-1:0]       req_fifo_full,
    input  logic [NUM_PORTS-1:0]       rsp_pop,
    output logic [NUM_PORTS*RSP_W-1:0] rsp_data,
    output logic [NUM_PORTS-1:0]       rsp_fifo_not_empty,
    output logic                       core_req_valid,
    input  logic                       core_req_ready,
    output logic [REQ_W-1:0]           core_req_data,
    output logic [PORT_W-1:0]          core_req_port,
    input  logic                       core_rsp_valid,
    input  logic [PORT_W-1:0]          core_rsp_port,
    input  logic [RSP_W-1:0]           core_rsp_data,
    output logic                       core_rsp_ready,
    output logic [NUM_PORTS*4-1:0]     out_cnt
`ifdef MMU_ARB_STATS_EN
   ,output logic [NUM_PORTS*16-1:0]    grant_cnt
`endif
);

    import mmu_port_arbiter_pkg::*;

    arb_state_t state, state_n;
    logic [NUM_PORTS-1:0] req_empty, rsp_full, rsp_empty, elig, pop;
    logic [REQ_W-1:0]     req_rd [NUM_PORTS];
    logic [3:0]           cnt [NUM_PORTS];
    logic [PORT_W-1:0]    grant, rr_ptr, pick;
    logic                 hs, tag_ok, rsp_fire, rsp_err;

    // First set bit of e at or after ptr, wrapping; lowest offset wins.
    function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] e,
                                                  input logic [PORT_W-1:0] ptr);
        logic [PORT_W-1:0] idx;
        rr_pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = PORT_W'((int'(ptr) + i) % NUM_PORTS);
            if (e[idx]) rr_pick = idx;
        end
    endfunction

    assign hs             = (state == ARB_ISSUE) && core_req_ready;
    assign tag_ok         = int'(core_rsp_port) < NUM_PORTS;
    // Out-of-range tags are accepted and dropped so the core never stalls on them.
    assign core_rsp_ready = tag_ok ? !rsp_full[core_rsp_port] : 1'b1;
    assign rsp_fire       = core_rsp_valid && core_rsp_ready;
    // Error: bad tag, or a response for a port with no outstanding credit.
    assign rsp_err        = rsp_fire && (!tag_ok || cnt[core_rsp_port] == 4'd0);
    assign pick           = rr_pick(elig, rr_ptr);

    always_comb
        for (int p = 0; p < NUM_PORTS; p++)
            elig[p] = !req_empty[p] && (cnt[p] < 4'(MAX_OUT));

    always_ff @(posedge clk)
        state <= rst ? ARB_IDLE : state_n;

    always_comb begin
        state_n = state;
        pop     = '0;
        case (state)
            ARB_IDLE: if (|elig) begin
                state_n   = ARB_LOAD;
                pop[pick] = 1'b1;
            end
            ARB_LOAD:  state_n = ARB_ISSUE;
            ARB_ISSUE: if (core_req_ready) state_n = ARB_IDLE;
            default:   state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_req_valid <= 1'b0;
            core_req_data  <= '0;
            core_req_port  <= '0;
            grant          <= '0;
            rr_ptr         <= '0;
            for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= '0;
        end else begin
            if (state == ARB_IDLE && |elig) grant <= pick;
            // FIFO read data lands during LOAD, one cycle after the IDLE pop.
            if (state == ARB_LOAD) begin
                core_req_data  <= req_rd[grant];
                core_req_port  <= grant;
                core_req_valid <= 1'b1;
            end
            if (hs) begin
                core_req_valid <= 1'b0;
                rr_ptr         <= PORT_W'((int'(grant) + 1) % NUM_PORTS);
            end
            for (int p = 0; p < NUM_PORTS; p++)
                cnt[p] <= cnt[p] + 4'(hs && grant == PORT_W'(p))
                                 - 4'(rsp_fire && !rsp_err && core_rsp_port == PORT_W'(p));
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        mmu_port_fifo #(.W(REQ_W), .PTR(FIFO_PTR)) u_req (
            .clk   (clk),
            .rst   (rst),
            .wr    (req_submit[i]),
            .wdata (req_data[i*REQ_W +: REQ_W]),
            .full  (req_fifo_full[i]),
            .rd    (pop[i]),
            .rdata (req_rd[i]),
            .empty (req_empty[i])
        );
        mmu_port_fifo #(.W(RSP_W), .PTR(FIFO_PTR)) u_rsp (
            .clk   (clk),
            .rst   (rst),
            .wr    (rsp_fire && tag_ok && core_rsp_port == PORT_W'(i)),
            .wdata (core_rsp_data),
            .full  (rsp_full[i]),
            .rd    (rsp_pop[i]),
            .rdata (rsp_data[i*RSP_W +: RSP_W]),
            .empty (rsp_empty[i])
        );
        assign rsp_fifo_not_empty[i] = !rsp_empty[i];
        assign out_cnt[i*4 +: 4]     = cnt[i];
    end

`ifdef MMU_ARB_STATS_EN
    logic [15:0] gcnt [NUM_PORTS];

    always_ff @(posedge clk)
        for (int p = 0; p < NUM_PORTS; p++)
            if (rst) gcnt[p] <= '0;
            else if (hs && grant == PORT_W'(p) && gcnt[p] != 16'hFFFF) gcnt[p] <= gcnt[p] + 16'd1;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
        assign grant_cnt[i*16 +: 16] = gcnt[i];
    end
`endif

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// tb_mmu_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (per-port queues and credit counts).
module tb_mmu_port_arbiter;

    localparam int NP = 4;
    localparam int RW = 17;
    localparam int SW = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_submit, req_fifo_full, rsp_pop, rsp_fifo_not_empty;
    logic [NP*RW-1:0]  req_data;
    logic [NP*SW-1:0]  rsp_data;
    logic              core_req_valid, core_req_ready;
    logic [RW-1:0]     core_req_data;
    logic [1:0]        core_req_port, core_rsp_port;
    logic              core_rsp_valid, core_rsp_ready;
    logic [SW-1:0]     core_rsp_data;
    logic [NP*4-1:0]   out_cnt;

    int checks = 0;
    int errors = 0;

    mmu_port_arbiter #(
        .NUM_PORTS(NP), .PORT_W(2), .REQ_W(RW), .RSP_W(SW), .FIFO_PTR(3), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_submit(req_submit), .req_data(req_data), .req_fifo_full(req_fifo_full),
        .rsp_pop(rsp_pop), .rsp_data(rsp_data), .rsp_fifo_not_empty(rsp_fifo_not_empty),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_data(core_req_data), .core_req_port(core_req_port),
        .core_rsp_valid(core_rsp_valid), .core_rsp_port(core_rsp_port),
        .core_rsp_data(core_rsp_data), .core_rsp_ready(core_rsp_ready),
        .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_submit = '0; req_data = '0; rsp_pop = '0;
        core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_rsp_port = '0; core_rsp_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_req_valid, core_req_data, core_req_port} !== 20'd0) begin
            errors++; $display("FAIL reset_req: got v=%b d=%h p=%0d expected 0", core_req_valid, core_req_data, core_req_port);
        end
        checks++;
        if ({req_fifo_full, rsp_fifo_not_empty} !== 8'd0) begin
            errors++; $display("FAIL reset_flags: got full=%b ne=%b expected 0", req_fifo_full, rsp_fifo_not_empty);
        end
        checks++;
        if (rsp_data !== '0) begin
            errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
        end
        checks++;
        if (out_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_out_cnt: got %h expected 0", out_cnt);
        end
        checks++;
        if (core_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL reset_rsp_ready: got %b expected 1", core_rsp_ready);
        end
    endtask

    task automatic test_single_port();
        int n;
        do_reset();
        core_req_ready = 1'b1;
        req_submit = 4'b0010;
        req_data[1*RW +: RW] = 17'h1_0005;
        tick();
        req_submit = '0;
        n = 0;
        do begin tick(); n++; end while (!core_req_valid && n < 20);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL single_latency: got %0d cycles expected 2", n);
        end
        checks++;
        if (core_req_data !== 17'h1_0005 || core_req_port !== 2'd1) begin
            errors++; $display("FAIL single_payload: got d=%h p=%0d expected d=10005 p=1", core_req_data, core_req_port);
        end
        tick();
        checks++;
        if (core_req_valid !== 1'b0 || out_cnt !== 16'h0010) begin
            errors++; $display("FAIL single_out_cnt: got v=%b cnt=%h expected v=0 cnt=0010", core_req_valid, out_cnt);
        end
    endtask

    task automatic test_all_ports();
        int seen[$];
        int when[$];
        int exp_p[5] = '{0, 1, 2, 3, 0};
        logic [RW-1:0] exp_d;
        do_reset();
        core_req_ready = 1'b1;
        req_submit = '1;
        for (int p = 0; p < NP; p++) req_data[p*RW +: RW] = 17'(32'h100 + p);
        tick();
        req_submit = '0;
        for (int c = 0; c < 40 && seen.size() < 5; c++) begin
            tick();
            req_submit = '0;
            if (core_req_valid) begin
                exp_d = (seen.size() == 4) ? 17'h1_FFFF : 17'(32'h100 + exp_p[seen.size()]);
                checks++;
                if (core_req_data !== exp_d) begin
                    errors++; $display("FAIL rr_data: got %h expected %h", core_req_data, exp_d);
                end
                seen.push_back(int'(core_req_port));
                when.push_back(c);
                if (seen.size() == 2) begin
                    req_submit = 4'b0001;
                    req_data[0 +: RW] = 17'h1_FFFF;
                end
            end
        end
        checks++;
        if (seen.size() != 5) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] != exp_p[i]) begin
                    errors++; $display("FAIL rr_order[%0d]: got port %0d expected %0d", i, seen[i], exp_p[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (when[i] - when[i-1] != 3) begin
                    errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, when[i] - when[i-1]);
                end
            end
        end
    endtask

    task automatic test_credit_limit();
        int hs = 0;
        do_reset();
        core_req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            req_submit = (i < 6) ? 4'b0100 : 4'b0000;
            req_data[2*RW +: RW] = 17'(100 + i);
            tick();
            if (core_req_valid) begin
                checks++;
                if (core_req_data !== 17'(100 + hs) || core_req_port !== 2'd2) begin
                    errors++; $display("FAIL credit_data: got d=%h p=%0d expected d=%h p=2", core_req_data, core_req_port, 17'(100 + hs));
                end
                hs++;
            end
        end
        req_submit = '0;
        checks++;
        if (hs != 4 || out_cnt !== 16'h0400) begin
            errors++; $display("FAIL credit_cap: got %0d issued cnt=%h expected 4 issued cnt=0400", hs, out_cnt);
        end
        core_rsp_valid = 1'b1; core_rsp_port = 2'd2; core_rsp_data = 30'h123;
        #1;
        checks++;
        if (core_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL credit_rsp_ready: got %b expected 1", core_rsp_ready);
        end
        tick();
        core_rsp_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_req_valid) begin
                checks++;
                if (core_req_data !== 17'd104) begin
                    errors++; $display("FAIL credit_fifth: got %h expected %h", core_req_data, 17'd104);
                end
                hs++;
            end
        end
        checks++;
        if (hs != 1 || out_cnt !== 16'h0400 || rsp_fifo_not_empty !== 4'b0100) begin
            errors++; $display("FAIL credit_after_rsp: got %0d issued cnt=%h ne=%b expected 1 cnt=0400 ne=0100", hs, out_cnt, rsp_fifo_not_empty);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        req_submit = 4'b1000;
        req_data[3*RW +: RW] = 17'h1_ABCD;
        tick();
        req_submit = '0;
        while (!core_req_valid && n < 10) begin tick(); n++; end
        checks++;
        if (!core_req_valid) begin
            errors++; $display("FAIL bp_timeout: got valid=0 expected 1");
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({core_req_valid, core_req_data, core_req_port, out_cnt} !== {1'b1, 17'h1_ABCD, 2'd3, 16'h0}) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h p=%0d cnt=%h expected v=1 d=1abcd p=3 cnt=0", i, core_req_valid, core_req_data, core_req_port, out_cnt);
            end
        end
        core_req_ready = 1'b1;
        tick();
        checks++;
        if (core_req_valid !== 1'b0 || out_cnt !== 16'h1000) begin
            errors++; $display("FAIL bp_release: got v=%b cnt=%h expected v=0 cnt=1000", core_req_valid, out_cnt);
        end
    endtask

    task automatic test_rsp_routing();
        do_reset();
        core_rsp_port = 2'd3;
        for (int i = 0; i < 8; i++) begin
            core_rsp_valid = 1'b1;
            core_rsp_data = 30'(i + 1);
            #1;
            checks++;
            if (core_rsp_ready !== 1'b1) begin
                errors++; $display("FAIL route_fill_ready[%0d]: got %b expected 1", i, core_rsp_ready);
            end
            tick();
        end
        core_rsp_data = 30'd99;
        #1;
        checks++;
        if (core_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL route_full_ready: got %b expected 0", core_rsp_ready);
        end
        tick();
        checks++;
        if (rsp_fifo_not_empty !== 4'b1000 || rsp_data !== '0) begin
            errors++; $display("FAIL route_no_pop: got ne=%b d3=%h expected ne=1000 d3=0", rsp_fifo_not_empty, rsp_data[3*SW +: SW]);
        end
        rsp_pop = 4'b1000;
        tick();
        rsp_pop = '0;
        checks++;
        if (rsp_data[3*SW +: SW] !== 30'd1) begin
            errors++; $display("FAIL route_pop1: got %h expected 1", rsp_data[3*SW +: SW]);
        end
        #1;
        checks++;
        if (core_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL route_ready_after_pop: got %b expected 1", core_rsp_ready);
        end
        tick();
        core_rsp_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            rsp_pop = 4'b1000;
            tick();
            checks++;
            if (rsp_data[3*SW +: SW] !== ((k == 9) ? 30'd99 : 30'(k))) begin
                errors++; $display("FAIL route_drain[%0d]: got %h expected %h", k, rsp_data[3*SW +: SW], (k == 9) ? 30'd99 : 30'(k));
            end
        end
        tick();
        rsp_pop = '0;
        checks++;
        if (rsp_fifo_not_empty !== 4'b0000 || rsp_data[3*SW +: SW] !== 30'd99) begin
            errors++; $display("FAIL route_empty_pop: got ne=%b d3=%h expected ne=0 d3=63", rsp_fifo_not_empty, rsp_data[3*SW +: SW]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        core_req_ready = 1'b1;
        req_submit = 4'b0010;
        req_data[1*RW +: RW] = 17'h0_0042;
        tick();
        req_submit = '0;
        repeat (5) tick();
        core_rsp_valid = 1'b1; core_rsp_port = 2'd0; core_rsp_data = 30'h5;
        tick();
        core_rsp_valid = 1'b0;
        checks++;
        if (out_cnt !== 16'h0010 || rsp_fifo_not_empty !== 4'b0001) begin
            errors++; $display("FAIL mid_setup: got cnt=%h ne=%b expected cnt=0010 ne=0001", out_cnt, rsp_fifo_not_empty);
        end
        core_req_ready = 1'b0;
        req_submit = 4'b0100;
        tick();
        req_submit = '0;
        while (!core_req_valid && n < 10) begin tick(); n++; end
        checks++;
        if (core_req_valid !== 1'b1) begin
            errors++; $display("FAIL mid_issue_timeout: got valid=%b expected 1", core_req_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (core_req_valid !== 1'b0 || out_cnt !== 16'h0 || rsp_fifo_not_empty !== 4'b0) begin
            errors++; $display("FAIL mid_reset: got v=%b cnt=%h ne=%b expected all 0", core_req_valid, out_cnt, rsp_fifo_not_empty);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [RW-1:0] m_req[NP][$];
        logic [SW-1:0] m_rsp[NP][$];
        logic [SW-1:0] m_rd[NP];
        int m_out[NP];
        logic [15:0] eo;
        logic [3:0] ene;
        logic [NP*SW-1:0] erd;
        logic exp_rdy;
        logic [RW-1:0] d;
        int rp, q;
        do_reset();
        for (int p = 0; p < NP; p++) begin m_out[p] = 0; m_rd[p] = '0; end
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                eo[p*4 +: 4] = 4'(m_out[p]);
                ene[p] = m_rsp[p].size() != 0;
                erd[p*SW +: SW] = m_rd[p];
            end
            checks++;
            if (out_cnt !== eo) begin
                errors++; $display("FAIL rnd_out_cnt @%0d: got %h expected %h", c, out_cnt, eo);
            end
            checks++;
            if (rsp_fifo_not_empty !== ene || req_fifo_full !== 4'b0) begin
                errors++; $display("FAIL rnd_flags @%0d: got ne=%b full=%b expected ne=%b full=0", c, rsp_fifo_not_empty, req_fifo_full, ene);
            end
            checks++;
            if (rsp_data !== erd) begin
                errors++; $display("FAIL rnd_rsp_data @%0d: got %h expected %h", c, rsp_data, erd);
            end
            core_req_ready = $urandom_range(0, 3) != 0;
            req_submit = '0; rsp_pop = '0; core_rsp_valid = 1'b0;
            rp = $urandom_range(0, NP - 1);
            if (m_out[rp] > 0 && $urandom_range(0, 1) == 1) begin
                core_rsp_valid = 1'b1;
                core_rsp_port = 2'(rp);
                core_rsp_data = 30'($urandom);
            end else core_rsp_port = 2'($urandom_range(0, NP - 1));
            for (int p = 0; p < NP; p++) rsp_pop[p] = $urandom_range(0, 3) == 0;
            #1;
            if (core_req_valid && core_req_ready) begin
                q = int'(core_req_port);
                checks++;
                if (m_req[q].size() == 0 || core_req_data !== m_req[q][0]) begin
                    errors++; $display("FAIL rnd_req @%0d: got p=%0d d=%h expected queue head (size %0d)", c, q, core_req_data, m_req[q].size());
                end
                if (m_req[q].size() != 0) void'(m_req[q].pop_front());
                m_out[q]++;
                checks++;
                if (m_out[q] > 4) begin
                    errors++; $display("FAIL rnd_credit @%0d: got %0d outstanding on port %0d expected <=4", c, m_out[q], q);
                end
            end
            for (int p = 0; p < NP; p++)
                if (m_req[p].size() < 6 && $urandom_range(0, 3) == 0) begin
                    d = 17'($urandom);
                    req_submit[p] = 1'b1;
                    req_data[p*RW +: RW] = d;
                    m_req[p].push_back(d);
                end
            exp_rdy = m_rsp[core_rsp_port].size() < 8;
            checks++;
            if (core_rsp_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_rsp_ready @%0d: got %b expected %b", c, core_rsp_ready, exp_rdy);
            end
            for (int p = 0; p < NP; p++)
                if (rsp_pop[p] && m_rsp[p].size() != 0) m_rd[p] = m_rsp[p].pop_front();
            if (core_rsp_valid && exp_rdy) begin
                m_rsp[rp].push_back(core_rsp_data);
                m_out[rp]--;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req_submit = '0; req_data = '0; rsp_pop = '0;
        core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_rsp_port = '0; core_rsp_data = '0;
        test_reset();
        test_single_port();
        test_all_ports();
        test_credit_limit();
        test_backpressure();
        test_rsp_routing();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
